// File: rtl/mips_pkg.sv
// mips_pkg
// Types and constants that the multicycle MIPS datapath blocks share.
// The multiply/divide unit uses these:
//   md_op_e    - encoding of the `op` input (MULT, MULTU, DIV, DIVU)
//   md_state_e - states of the multiply/divide control FSM
//   MD_ITER    - number of radix-2 iterations per operation
//   magnitude  - absolute value of a two's-complement word, given its sign
package mips_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Two's-complement magnitude. The 0x80000000 case comes back as
    // 0x80000000, which is the correct unsigned magnitude 2^31.
    function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] x,
                                                      input logic              neg);
        return neg ? (MD_WIDTH'(0) - x) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative 32-bit multiply/divide unit that produces the HI/LO registers
// for MULT, MULTU, DIV and DIVU. Each operation runs on operand magnitudes
// for 32 radix-2 steps. One FIX cycle then applies the sign and writes HI/LO.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   start, op         - request and operation code (sampled in IDLE/DONE)
//   operand_a/_b      - rs / rt values, latched when the request is accepted
//   busy              - high while running (RUN and FIX)
//   done              - one-cycle pulse; hi/lo are valid in that cycle
//   div_zero          - qualifies done: the divide had a zero divisor
//   hi, lo            - architectural HI/LO registers
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MD_ITER);

    md_state_e          state_q,    state_d;
    logic [CW-1:0]      count_q,    count_d;
    logic               is_div_q,   is_div_d;
    logic               neg_lo_q,   neg_lo_d;   // negate product / quotient
    logic               neg_hi_q,   neg_hi_d;   // negate remainder (divide only)
    logic [WIDTH-1:0]   opnd_q,     opnd_d;     // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q,      acc_d;      // product, or {remainder, quotient}
    logic [WIDTH-1:0]   hi_q,       hi_d;
    logic [WIDTH-1:0]   lo_q,       lo_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               div_zero_q, div_zero_d;

    // Operand decode and the datapath for a single step
    md_op_e             op_in;
    logic               in_div, in_signed, sign_a, sign_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        op_in     = md_op_e'(op);
        in_div    = (op_in == MD_DIV)  || (op_in == MD_DIVU);
        in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
        sign_a    = in_signed & operand_a[WIDTH-1];
        sign_b    = in_signed & operand_b[WIDTH-1];

        // Multiply: add the multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the 65-bit result right.
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide (restoring): shift the next dividend bit into the 33-bit
        // partial remainder and keep the subtraction only when it does not borrow.
        div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff   = div_rem_sh - {1'b0, opnd_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH])
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end

        prod_fix = neg_lo_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    end

    // NOTE: each _d starts from its _q, so a path that leaves a signal
    // unassigned holds state in the flop and cannot infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    div_zero_d = 1'b0;
                    if (in_div && (operand_b == '0)) begin
                        // A zero divisor finishes immediately and leaves HI/LO as they are.
                        state_d    = DONE;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        count_d  = CW'(MD_ITER - 1);
                        is_div_d = in_div;
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = in_div ? sign_a : (sign_a ^ sign_b);
                        if (in_div) begin
                            opnd_d = magnitude(operand_b, sign_b);
                            acc_d  = {{WIDTH{1'b0}}, magnitude(operand_a, sign_a)};
                        end else begin
                            opnd_d = magnitude(operand_a, sign_a);
                            acc_d  = {{WIDTH{1'b0}}, magnitude(operand_b, sign_b)};
                        end
                    end
                end
            end
            RUN: begin
                acc_d   = acc_step;
                count_d = count_q - 1'b1;
                if (count_q == '0)
                    state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                if (is_div_q) begin
                    hi_d = neg_hi_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_lo_q ? (WIDTH'(0) - acc_q[WIDTH-1:0])       : acc_q[WIDTH-1:0];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        // The status outputs are registered versions of the next state.
        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state updates use non-blocking assignments, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the multicycle MIPS datapath. It sits directly downstream of the register file and consumes `read_data_1`/`read_data_2` as operands for MULT, MULTU, DIV and DIVU. Results are held in architectural HI/LO registers, which feed the write-back mux for MFHI/MFLO. The control FSM stalls the main datapath on `busy` and resumes on `done`.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only when the unit accepts (IDLE or DONE).
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  32  rs value (multiplicand or dividend), from `read_data_1`.
- `operand_b`  in  32  rt value (multiplier or divisor), from `read_data_2`.
- `busy`  out  1  operation in progress; start is ignored.
- `done`  out  1  one-cycle pulse; HI/LO are valid in that cycle.
- `div_zero`  out  1  valid with `done`; divide with `operand_b == 0`.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.

Reset and clock: reset is synchronous, active-high, named `reset`; the clock is `clock`.

## Operation
- FSM states:
  - IDLE → RUN on `start`; latches `op`, operand magnitudes (signed ops take |x|), result sign flags, and sets `count = 31`.
  - IDLE → DONE directly for DIV/DIVU with `operand_b == 0`.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring step into a 33-bit partial remainder with a 32-bit quotient.
    - `count` decrements each cycle; on `count == 0`, go to FIX.
  - FIX: applies two's-complement sign correction and writes HI/LO, then → DONE.
  - DONE: `done = 1` for exactly one cycle, then → IDLE. A `start` in DONE is accepted exactly as in IDLE (back-to-back operation).
- Signed multiply: product negated iff the operand signs differ.
- Signed divide:
  - Quotient truncates toward zero; negated iff signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
- Divide by zero: `div_zero = 1` with `done`; HI/LO unchanged.
- `div_zero` is cleared when the next operation is accepted.
- HI/LO change only in FIX; they hold their value at all other times, including across IDLE.
- Operand changes after acceptance are ignored, because operands are latched.
- `start` while `busy` is ignored; it is not queued.
- Reset in any state: next cycle is IDLE; `busy`, `done`, `div_zero` are 0; `hi` and `lo` are 0x00000000; the in-flight operation is discarded.

## Timing
- `start` is accepted at edge k; `busy` is high in cycles k+1 through k+33 (RUN ×32, FIX ×1).
- `done` is high in cycle k+34 (the cycle after edge k+33), with new HI/LO visible in that same cycle.
- Latency from accept to `done` is 34 cycles for every non-zero-divisor operation; there is no early termination.
- Divide by zero: `done` and `div_zero` are high in cycle k+1; `busy` is never asserted.
- `busy` is 0 in IDLE and DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg`:
  - `op` encodings: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - FSM state enum: IDLE, RUN, FIX, DONE.
  - `MD_ITER = 32`.
- Single module; no sub-module is natural. The shift/add/subtract datapath is small and tightly coupled to the FSM counter.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001; `done` exactly 34 cycles after the accept edge.
- MULT −3 × 7 → hi 0xFFFFFFFF, lo 0xFFFFFFEB. DIVU 100 / 7 → lo 14, hi 2.
- DIV −7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0.
- DIV 5 / 0 → `done` and `div_zero` high 1 cycle after accept; `busy` stays 0; hi/lo keep their prior values.
- Second `start` at cycle 5 of RUN with different operands → ignored; the first result completes unchanged. A `start` during DONE → accepted; its result arrives 34 cycles later.
- Reset asserted at cycle 10 of a MULT → next cycle hi = lo = 0, `busy` = 0; `done` never pulses for the aborted operation.
